// File: rtl/mig_pkg.sv
// Shared types and sizes for the hot-address drain path: CAM geometry and the
// drain FSM state encoding.
package mig_pkg;

    localparam int NUM_ENTRY  = 25;
    localparam int INDEX_SIZE = $clog2(NUM_ENTRY);
    localparam int ADDR_SIZE  = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } drain_state_e;

endpackage

// File: rtl/mig_prio_pick.sv
// Combinational lowest-set-bit finder over the drain mask; also flags when the
// picked bit is the only one left.
module mig_prio_pick
    import mig_pkg::*;
(
    input  logic [NUM_ENTRY-1:0]  i_mask,
    output logic [INDEX_SIZE-1:0] o_index,
    output logic                  o_any,
    output logic                  o_last
);

    logic [NUM_ENTRY-1:0] w_rest;

    // Scan downward so the lowest set index is the final assignment.
    always_comb begin
        o_index = '0;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_index = INDEX_SIZE'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves exactly the bits above the pick.
    assign w_rest = i_mask & (i_mask - NUM_ENTRY'(1));
    assign o_any  = |i_mask;
    assign o_last = o_any && (w_rest == '0);

endmodule

// File: rtl/mig_addr_drain.sv
// Epoch-based drain of the hot-address CAM: query, snapshot on query_ready, then
// stream the non-zero entries hottest-first to the page-migration engine.
module mig_addr_drain
    import mig_pkg::*;
#(
    parameter int TIMER_W       = 32,
    parameter int PERIOD_CYCLES = 1_000_000,
    parameter int WAIT_TIMEOUT  = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_cfg_enable,
    input  logic                           i_sw_trigger,
    output logic                           o_query_en,
    input  logic                           i_query_ready,
    input  logic [NUM_ENTRY*ADDR_SIZE-1:0] i_cam_addr,
    output logic                           o_mig_valid,
    output logic [ADDR_SIZE-1:0]           o_mig_addr,
    output logic                           o_mig_last,
    input  logic                           i_mig_ready,
    output logic                           o_busy,
    output logic                           o_timeout_err
);

    localparam int                  WCNT_W     = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(PERIOD_CYCLES - 1);
    localparam logic [WCNT_W-1:0]   WAIT_LAST  = WCNT_W'(WAIT_TIMEOUT - 1);

    drain_state_e          r_state;
    drain_state_e          w_next;
    logic [TIMER_W-1:0]    r_timer;
    logic                  r_pending;
    logic [WCNT_W-1:0]     r_wait_cnt;
    logic [ADDR_SIZE-1:0]  r_snap [NUM_ENTRY];
    logic [NUM_ENTRY-1:0]  r_mask;
    logic                  r_query_en;
    logic                  r_mig_valid;
    logic [ADDR_SIZE-1:0]  r_mig_addr;
    logic                  r_mig_last;
    logic                  r_timeout_err;

    logic [NUM_ENTRY-1:0]  w_cap_mask;
    logic [INDEX_SIZE-1:0] w_pick_idx;
    logic                  w_pick_any;
    logic                  w_pick_last;
    logic                  w_start;
    logic                  w_timeout;
    logic                  w_capture;
    logic                  w_load;
    logic                  w_drain_done;

    mig_prio_pick u_pick (
        .i_mask  (r_mask),
        .o_index (w_pick_idx),
        .o_any   (w_pick_any),
        .o_last  (w_pick_last)
    );

    always_comb begin
        w_cap_mask = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            w_cap_mask[i] = (i_cam_addr[i*ADDR_SIZE +: ADDR_SIZE] != '0);
        end
    end

    assign w_start      = i_cfg_enable && ((r_timer == TIMER_LAST) || i_sw_trigger || r_pending);
    assign w_timeout    = (r_wait_cnt == WAIT_LAST) && !i_query_ready;
    assign w_capture    = (r_state == WAIT) && i_query_ready;
    // The mask only holds entries not yet presented, so an empty mask plus a
    // free output register means the epoch is finished.
    assign w_load       = (r_state == DRAIN) && w_pick_any && (!r_mig_valid || i_mig_ready);
    assign w_drain_done = !w_pick_any && (!r_mig_valid || i_mig_ready);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = REQ;
            REQ:     w_next = WAIT;
            WAIT: begin
                if (i_query_ready) begin
                    w_next = (w_cap_mask != '0) ? DRAIN : IDLE;
                end else if (w_timeout) begin
                    w_next = IDLE;
                end
            end
            DRAIN:   if (w_drain_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_pending     <= 1'b0;
            r_wait_cnt    <= '0;
            r_query_en    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_query_en <= (w_next == REQ);
            if ((r_state == IDLE) && i_cfg_enable && !w_start) begin
                r_timer <= r_timer + TIMER_W'(1);
            end else begin
                r_timer <= '0;
            end
            if ((r_state == IDLE) && w_start) begin
                r_pending <= 1'b0;
            end else if ((r_state != IDLE) && i_sw_trigger) begin
                r_pending <= 1'b1;
            end
            if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if ((r_state == WAIT) && w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                r_snap[i] <= '0;
            end
            r_mask <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                r_snap[i] <= i_cam_addr[i*ADDR_SIZE +: ADDR_SIZE];
            end
            r_mask <= w_cap_mask;
        end else if (w_load) begin
            r_mask[w_pick_idx] <= 1'b0;
        end
    end

    // Output beat register: refills on the handshake cycle for 1 beat/cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mig_valid <= 1'b0;
            r_mig_addr  <= '0;
            r_mig_last  <= 1'b0;
        end else if (w_load) begin
            r_mig_valid <= 1'b1;
            r_mig_addr  <= r_snap[w_pick_idx];
            r_mig_last  <= w_pick_last;
        end else if (r_mig_valid && i_mig_ready) begin
            r_mig_valid <= 1'b0;
            r_mig_addr  <= '0;
            r_mig_last  <= 1'b0;
        end
    end

    assign o_query_en    = r_query_en;
    assign o_mig_valid   = r_mig_valid;
    assign o_mig_addr    = r_mig_addr;
    assign o_mig_last    = r_mig_last;
    assign o_busy        = (r_state != IDLE);
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mig_addr_drain.sv
// Directed bench for mig_addr_drain with a 16-cycle epoch period.
module tb_mig_addr_drain;
    import mig_pkg::*;

    logic                           i_clk = 1'b0;
    logic                           i_rst_n = 1'b0;
    logic                           i_cfg_enable = 1'b0;
    logic                           i_sw_trigger = 1'b0;
    logic                           o_query_en;
    logic                           i_query_ready = 1'b0;
    logic [NUM_ENTRY*ADDR_SIZE-1:0] i_cam_addr;
    logic                           o_mig_valid;
    logic [ADDR_SIZE-1:0]           o_mig_addr;
    logic                           o_mig_last;
    logic                           i_mig_ready = 1'b1;
    logic                           o_busy;
    logic                           o_timeout_err;

    logic [ADDR_SIZE-1:0] cam [NUM_ENTRY];
    int checks = 0;
    int failures = 0;

    mig_addr_drain #(.TIMER_W(32), .PERIOD_CYCLES(16), .WAIT_TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfg_enable(i_cfg_enable),
        .i_sw_trigger(i_sw_trigger), .o_query_en(o_query_en),
        .i_query_ready(i_query_ready), .i_cam_addr(i_cam_addr),
        .o_mig_valid(o_mig_valid), .o_mig_addr(o_mig_addr), .o_mig_last(o_mig_last),
        .i_mig_ready(i_mig_ready), .o_busy(o_busy), .o_timeout_err(o_timeout_err)
    );

    always #5 i_clk = ~i_clk;

    always_comb begin
        i_cam_addr = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            i_cam_addr[i*ADDR_SIZE +: ADDR_SIZE] = cam[i];
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_cam3(input logic [ADDR_SIZE-1:0] a0, input logic [ADDR_SIZE-1:0] a1,
                            input logic [ADDR_SIZE-1:0] a2);
        for (int i = 0; i < NUM_ENTRY; i++) cam[i] = '0;
        cam[0] = a0;
        cam[1] = a1;
        cam[2] = a2;
    endtask

    // Software-triggered query; returns in the REQ cycle.
    task automatic start_epoch();
        i_cfg_enable = 1'b1;
        i_sw_trigger = 1'b1;
        step();
        i_sw_trigger = 1'b0;
        i_cfg_enable = 1'b0;
    endtask

    // CAM answers in the first WAIT cycle; returns in the snapshot cycle.
    task automatic cam_answer();
        step();
        i_query_ready = 1'b1;
        step();
        i_query_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({o_query_en, o_mig_valid, o_mig_last, o_timeout_err, o_busy} !== 5'b0 || o_mig_addr !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got qen=%b v=%b l=%b err=%b busy=%b addr=%h, want all 0",
                     o_query_en, o_mig_valid, o_mig_last, o_timeout_err, o_busy, o_mig_addr);
        end
        i_rst_n = 1'b1;
        step();
        checks++;
        if (o_busy !== 1'b0 || o_query_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: got busy=%b qen=%b, want 0 0", o_busy, o_query_en);
        end
    endtask

    task automatic test_timer_epoch();
        logic [ADDR_SIZE-1:0] exp_a [3];
        logic                 exp_l [3];
        int first = 0;
        int pulses = 0;
        exp_a[0] = 22'h3A; exp_a[1] = 22'h11; exp_a[2] = 22'h7;
        exp_l[0] = 1'b0;   exp_l[1] = 1'b0;   exp_l[2] = 1'b1;
        set_cam3(22'h3A, 22'h11, 22'h7);
        i_mig_ready = 1'b1;
        i_cfg_enable = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            step();
            if (o_query_en === 1'b1) begin
                pulses++;
                if (first == 0) first = n;
            end
        end
        checks++;
        if (first != 16 || pulses != 1) begin
            failures++;
            $display("FAIL timer_query_cycle: got first=%0d pulses=%0d, want 16 1", first, pulses);
        end
        cam_answer();
        checks++;
        if (o_mig_valid !== 1'b0 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL timer_snapshot_cycle: got v=%b busy=%b, want 0 1", o_mig_valid, o_busy);
        end
        pulses = 0;
        for (int b = 0; b < 3; b++) begin
            step();
            if (o_query_en === 1'b1) pulses++;
            checks++;
            if (o_mig_valid !== 1'b1 || o_mig_addr !== exp_a[b] || o_mig_last !== exp_l[b]) begin
                failures++;
                $display("FAIL timer_beat%0d: got v=%b addr=%h last=%b, want 1 %h %b",
                         b, o_mig_valid, o_mig_addr, o_mig_last, exp_a[b], exp_l[b]);
            end
        end
        step();
        if (o_query_en === 1'b1) pulses++;
        i_cfg_enable = 1'b0;
        checks++;
        if (o_mig_valid !== 1'b0 || o_busy !== 1'b0 || pulses != 0) begin
            failures++;
            $display("FAIL timer_epoch_end: got v=%b busy=%b extra_qen=%0d, want 0 0 0",
                     o_mig_valid, o_busy, pulses);
        end
    endtask

    task automatic test_backpressure();
        logic                 rdy   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic                 exp_v [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [ADDR_SIZE-1:0] exp_a [5] = '{22'h5, 22'h5, 22'h9, 22'h9, 22'h0};
        logic                 exp_l [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        set_cam3(22'h5, 22'h0, 22'h9);
        i_mig_ready = 1'b1;
        start_epoch();
        checks++;
        if (o_query_en !== 1'b1) begin
            failures++;
            $display("FAIL bp_query_en: got %b, want 1", o_query_en);
        end
        cam_answer();
        for (int j = 0; j < 5; j++) begin
            step();
            checks++;
            if (o_mig_valid !== exp_v[j] || (exp_v[j] && (o_mig_addr !== exp_a[j] || o_mig_last !== exp_l[j]))) begin
                failures++;
                $display("FAIL bp_cycle%0d: got v=%b addr=%h last=%b, want %b %h %b",
                         j, o_mig_valid, o_mig_addr, o_mig_last, exp_v[j], exp_a[j], exp_l[j]);
            end
            i_mig_ready = rdy[j];
        end
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle_after: got busy=%b, want 0", o_busy);
        end
        i_mig_ready = 1'b1;
    endtask

    task automatic test_empty();
        int seen = 0;
        set_cam3(22'h0, 22'h0, 22'h0);
        start_epoch();
        step();
        checks++;
        if (o_busy !== 1'b1) begin
            failures++;
            $display("FAIL empty_wait_busy: got %b, want 1", o_busy);
        end
        i_query_ready = 1'b1;
        step();
        i_query_ready = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL empty_idle_after_capture: got busy=%b, want 0", o_busy);
        end
        for (int n = 0; n < 4; n++) begin
            if (o_mig_valid === 1'b1) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL empty_no_beats: got %0d valid cycles, want 0", seen);
        end
    endtask

    task automatic test_trigger_drain();
        int extra = 0;
        set_cam3(22'h1, 22'h2, 22'h3);
        i_mig_ready = 1'b1;
        start_epoch();
        cam_answer();
        step();
        checks++;
        if (o_mig_valid !== 1'b1 || o_mig_addr !== 22'h1) begin
            failures++;
            $display("FAIL trig_beat0: got v=%b addr=%h, want 1 000001", o_mig_valid, o_mig_addr);
        end
        i_sw_trigger = 1'b1;
        i_cfg_enable = 1'b1;
        step();
        i_sw_trigger = 1'b0;
        if (o_query_en === 1'b1) extra++;
        step();
        if (o_query_en === 1'b1) extra++;
        checks++;
        if (o_mig_addr !== 22'h3 || o_mig_last !== 1'b1) begin
            failures++;
            $display("FAIL trig_last_beat: got addr=%h last=%b, want 000003 1", o_mig_addr, o_mig_last);
        end
        step();
        if (o_query_en === 1'b1) extra++;
        checks++;
        if (o_mig_valid !== 1'b0 || o_busy !== 1'b0 || extra != 0) begin
            failures++;
            $display("FAIL trig_idle_gap: got v=%b busy=%b early_qen=%0d, want 0 0 0",
                     o_mig_valid, o_busy, extra);
        end
        step();
        checks++;
        if (o_query_en !== 1'b1) begin
            failures++;
            $display("FAIL trig_second_query: got qen=%b, want 1", o_query_en);
        end
        i_cfg_enable = 1'b0;
        set_cam3(22'h0, 22'h0, 22'h0);
        cam_answer();
        i_cfg_enable = 1'b1;
        extra = 0;
        for (int n = 0; n < 5; n++) begin
            step();
            if (o_query_en === 1'b1) extra++;
        end
        i_cfg_enable = 1'b0;
        checks++;
        if (extra != 0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL trig_no_extra_query: got qen_count=%0d busy=%b, want 0 0", extra, o_busy);
        end
    endtask

    task automatic test_timeout();
        int first = 0;
        set_cam3(22'h0, 22'h0, 22'h0);
        start_epoch();
        repeat (8) step();
        checks++;
        if (o_busy !== 1'b1 || o_timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL to_still_waiting: got busy=%b err=%b, want 1 0", o_busy, o_timeout_err);
        end
        step();
        checks++;
        if (o_busy !== 1'b0 || o_timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL to_expired: got busy=%b err=%b, want 0 1", o_busy, o_timeout_err);
        end
        i_cfg_enable = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            step();
            if (o_query_en === 1'b1 && first == 0) first = n;
        end
        i_cfg_enable = 1'b0;
        checks++;
        if (first != 16) begin
            failures++;
            $display("FAIL to_timer_restart: got query at cycle %0d, want 16", first);
        end
        cam_answer();
        step();
        checks++;
        if (o_busy !== 1'b0 || o_timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL to_sticky: got busy=%b err=%b, want 0 1", o_busy, o_timeout_err);
        end
    endtask

    task automatic test_reset_mid_drain();
        int seen = 0;
        for (int i = 0; i < NUM_ENTRY; i++) cam[i] = (i < 5) ? ADDR_SIZE'(32'h101 + i) : '0;
        i_mig_ready = 1'b1;
        start_epoch();
        cam_answer();
        step();
        step();
        checks++;
        if (o_mig_valid !== 1'b1 || o_mig_addr !== 22'h102) begin
            failures++;
            $display("FAIL rst_beat2: got v=%b addr=%h, want 1 000102", o_mig_valid, o_mig_addr);
        end
        #1;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_query_en, o_mig_valid, o_mig_last, o_timeout_err, o_busy} !== 5'b0 || o_mig_addr !== '0) begin
            failures++;
            $display("FAIL rst_async_clear: got qen=%b v=%b l=%b err=%b busy=%b addr=%h, want all 0",
                     o_query_en, o_mig_valid, o_mig_last, o_timeout_err, o_busy, o_mig_addr);
        end
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step();
            if (o_mig_valid === 1'b1 || o_busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_no_beats_after: got %0d active cycles, want 0", seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_ENTRY; i++) cam[i] = '0;
        test_reset();
        test_timer_epoch();
        test_backpressure();
        test_empty();
        test_trigger_drain();
        test_timeout();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
